// File: rtl/mul8_seq_ctrl.sv
// 8x8 sequential multiplier built on one shared 4x4 carry-save array.
// Four nibble products are accumulated over four cycles, then done pulses.
module csa_multiplier (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2;

  // Partial products, two carry-save rows, final ripple add
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = q[i] ? (8'(m) << i) : 8'h00;
    end
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2])
         | (pp[1] & pp[2])) << 1;
    s2 = s1 ^ c1 ^ pp[3];
    c2 = ((s1 & c1) | (s1 & pp[3])
         | (c1 & pp[3])) << 1;
    p  = s2 + c2;
  end

endmodule

module mul8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, nxt;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [7:0]  opa, opb;
  logic [3:0]  m, q;
  logic [3:0]  sh;
  logic [7:0]  p;
  logic [15:0] term, sum;

  csa_multiplier u_mul (
    .m (m),
    .q (q),
    .p (p)
  );

  // Nibble selection and shift for the current step; zero when not multiplying
  always_comb begin
    m  = 4'h0;
    q  = 4'h0;
    sh = 4'd0;
    if (state == MUL) begin
      unique case (step)
        2'd0: begin m = opa[3:0]; q = opb[3:0]; sh = 4'd0; end
        2'd1: begin m = opa[7:4]; q = opb[3:0]; sh = 4'd4; end
        2'd2: begin m = opa[3:0]; q = opb[7:4]; sh = 4'd4; end
        2'd3: begin m = opa[7:4]; q = opb[7:4]; sh = 4'd8; end
      endcase
    end
  end

  assign term = {8'h00, p} << sh;
  assign sum  = acc + term;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = MUL;
      MUL:     if (step == 2'd3) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Operand capture, accumulation and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step    <= 2'd0;
      acc     <= 16'h0000;
      opa     <= 8'h00;
      opb     <= 8'h00;
      product <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opa  <= a;
            opb  <= b;
            acc  <= 16'h0000;
            step <= 2'd0;
          end
        end
        MUL: begin
          acc  <= sum;
          step <= step + 2'd1;
          if (step == 2'd3) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: directed cases, reset abort, streaming,
// and randomized operands checked against plain a*b arithmetic.
module tb_mul8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;

  mul8_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and observe it for 10 cycles.
  // mode 0: quiet; 1: poke start with a=15,b=10; 2: random pokes.
  task automatic run_op(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  int          mode,
    output int          busy_cyc,
    output int          done_cyc,
    output int          done_cnt,
    output int          early_chg,
    output logic [15:0] res
  );
    logic [15:0] prev;
    busy_cyc  = 0;
    done_cyc  = -1;
    done_cnt  = 0;
    early_chg = 0;
    res       = 16'h0000;
    prev      = product;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = i;
        res = product;
      end else if (done_cnt == 0 && product !== prev) begin
        early_chg++;
      end
      if (mode == 1 && i <= 5) begin
        start = 1'b1; a = 8'd15; b = 8'd10;
      end else if (mode == 2 && i <= 5) begin
        start = 1'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt == 0) res = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (product !== 16'h0000) begin
      errors++; $display("FAIL reset_product: got %h want 0000", product);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_zero();
    int bc, dc, dn, ec;
    logic [15:0] r;
    run_op(8'd0, 8'd10, 0, bc, dc, dn, ec, r);
    checks++;
    if (bc != 5) begin
      errors++; $display("FAIL zero_busy_cycles: got %0d want 5", bc);
    end
    checks++;
    if (dc != 5) begin
      errors++; $display("FAIL zero_done_cycle: got %0d want 5", dc);
    end
    checks++;
    if (dn != 1) begin
      errors++; $display("FAIL zero_done_count: got %0d want 1", dn);
    end
    checks++;
    if (r !== 16'h0000) begin
      errors++; $display("FAIL zero_product: got %h want 0000", r);
    end
  endtask

  task automatic test_directed();
    logic [7:0] xs [4] = '{8'd5, 8'd9, 8'd200, 8'd255};
    logic [7:0] ys [4] = '{8'd5, 8'd5, 8'd150, 8'd255};
    int bc, dc, dn, ec;
    logic [15:0] r, exp;
    for (int k = 0; k < 4; k++) begin
      exp = 16'(xs[k]) * 16'(ys[k]);
      run_op(xs[k], ys[k], 0, bc, dc, dn, ec, r);
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL dir_product %0d*%0d: got %0d want %0d",
                 xs[k], ys[k], r, exp);
      end
      checks++;
      if (dn != 1 || dc != 5) begin
        errors++;
        $display("FAIL dir_done %0d*%0d: got cnt=%0d cyc=%0d want 1,5",
                 xs[k], ys[k], dn, dc);
      end
      checks++;
      if (ec != 0) begin
        errors++;
        $display("FAIL dir_early_change: got %0d want 0", ec);
      end
    end
  endtask

  task automatic test_ignore_start();
    int bc, dc, dn, ec;
    logic [15:0] r;
    run_op(8'd12, 8'd13, 1, bc, dc, dn, ec, r);
    checks++;
    if (r !== 16'd156) begin
      errors++; $display("FAIL ignore_product: got %0d want 156", r);
    end
    checks++;
    if (dn != 1) begin
      errors++; $display("FAIL ignore_done_count: got %0d want 1", dn);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ignore_requeued: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, dn, ec, seen_done, bad_prod;
    logic [15:0] r;
    a = 8'd255; b = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async: got busy=%b done=%b prod=%h want 0,0,0000",
               busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen_done = 0;
    bad_prod  = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      if (product !== 16'h0000) bad_prod++;
      if (busy) bad_prod++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL midreset_done: got %0d pulses want 0", seen_done);
    end
    checks++;
    if (bad_prod != 0) begin
      errors++; $display("FAIL midreset_idle: got %0d bad cycles want 0", bad_prod);
    end
    run_op(8'd3, 8'd4, 0, bc, dc, dn, ec, r);
    checks++;
    if (r !== 16'd12 || dc != 5) begin
      errors++;
      $display("FAIL midreset_restart: got %0d at cyc %0d want 12 at 5", r, dc);
    end
  endtask

  task automatic test_back_to_back();
    int bad_done, bad_busy, bad_prod, ndone, waited;
    bit exp_done, exp_busy;
    bad_done = 0; bad_busy = 0; bad_prod = 0; ndone = 0;
    a = 8'd15; b = 8'd10; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp_done = ((i - 1) % 6) == 4;
      exp_busy = ((i - 1) % 6) != 5;
      if (done !== exp_done) bad_done++;
      if (busy !== exp_busy) bad_busy++;
      if (done) begin
        ndone++;
        if (product !== 16'd150) bad_prod++;
      end
    end
    start = 1'b0;
    checks++;
    if (bad_done != 0 || ndone != 3) begin
      errors++;
      $display("FAIL b2b_done: got %0d bad cycles, %0d pulses want 0,3",
               bad_done, ndone);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++; $display("FAIL b2b_busy: got %0d bad cycles want 0", bad_busy);
    end
    checks++;
    if (bad_prod != 0) begin
      errors++; $display("FAIL b2b_product: got %0d wrong want 0", bad_prod);
    end
    waited = 0;
    while (busy && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    int bc, dc, dn, ec;
    logic [7:0]  x, y;
    logic [15:0] r, exp;
    for (int k = 0; k < 16; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      exp = 16'(x) * 16'(y);
      run_op(x, y, (k % 2) * 2, bc, dc, dn, ec, r);
      checks++;
      if (r !== exp || dn != 1 || dc != 5 || bc != 5 || ec != 0) begin
        errors++;
        $display("FAIL rand %0d*%0d: got %0d cnt=%0d cyc=%0d busy=%0d want %0d,1,5,5",
                 x, y, r, dn, dc, bc, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
